// File: rtl/paralelo_serial.sv
// paralelo_serial
// Byte-to-serial transmitter for the PHY lane. Bytes arrive from the link
// layer over a valid/ready handshake. They are shifted out MSB-first, one bit
// per clk_32f cycle. After reset a run of SYNC_BYTES comma bytes (IDLE_CHAR)
// is sent so the receiver can lock. Any byte slot with no pending data is
// filled with IDLE_CHAR.
//
// Ports:
//   clk_32f    in   bit clock, all state changes on its rising edge
//   reset      in   asynchronous, active-low reset
//   data_in    in   [7:0] parallel byte from the link layer
//   valid_in   in   data_in valid, held by upstream until accepted
//   ready_out  out  block can take a byte this cycle
//   data_out   out  serial bit stream, MSB first
//   active_out out  synchronisation finished, data transfer enabled

module paralelo_serial #(
  parameter logic [7:0] IDLE_CHAR  = 8'hBC,
  parameter int         SYNC_BYTES = 5
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       data_out,
  output logic       active_out
);

  typedef enum logic {
    SYNC,
    ACTIVE
  } state_t;

  localparam logic [3:0] SYNC_LAST = 4'(SYNC_BYTES - 1);

  state_t     state, state_next;
  logic [3:0] sync_cnt, sync_cnt_next;
  logic [7:0] sr;
  logic [2:0] bit_cnt;
  logic [7:0] hold;
  logic       hold_full;
  logic       boundary;
  logic       accept;

  // The last bit of the current byte is on the line; the next edge
  // reloads the shift register.
  assign boundary = (bit_cnt == 3'd7);

  // ready_out only depends on registered state, so upstream sees a clean
  // handshake regardless of how valid_in toggles.
  assign accept     = valid_in & ready_out;
  assign ready_out  = (state == ACTIVE) & ~hold_full;
  assign active_out = (state == ACTIVE);
  assign data_out   = sr[7];

  // FSM state and sync byte counter registers.
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state    <= SYNC;
      sync_cnt <= 4'd0;
    end else begin
      state    <= state_next;
      sync_cnt <= sync_cnt_next;
    end
  end

  // Count complete comma bytes at each boundary. The switch to ACTIVE
  // happens on the boundary of the last one, and that edge still loads
  // IDLE_CHAR because hold cannot be full while in SYNC.
  always_comb begin
    state_next    = state;
    sync_cnt_next = sync_cnt;
    case (state)
      SYNC: begin
        if (boundary) begin
          if (sync_cnt == SYNC_LAST) begin
            state_next    = ACTIVE;
            sync_cnt_next = 4'd0;
          end else begin
            sync_cnt_next = sync_cnt + 4'd1;
          end
        end
      end
      ACTIVE: begin
        state_next = ACTIVE;
      end
      default: begin
        state_next    = SYNC;
        sync_cnt_next = 4'd0;
      end
    endcase
  end

  // Shift register, bit counter and one-byte holding register.
  // A byte accepted on a boundary edge is not bypassed into sr: sr samples
  // the old (empty) hold and loads IDLE_CHAR, and the new byte goes out in
  // the following slot. Accept and reload-from-hold can never coincide,
  // because ready_out is low whenever hold is full.
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      sr        <= IDLE_CHAR;
      bit_cnt   <= 3'd0;
      hold      <= 8'd0;
      hold_full <= 1'b0;
    end else begin
      if (boundary) begin
        bit_cnt <= 3'd0;
        sr      <= hold_full ? hold : IDLE_CHAR;
      end else begin
        bit_cnt <= bit_cnt + 3'd1;
        sr      <= {sr[6:0], 1'b0};
      end

      if (accept) begin
        hold      <= data_in;
        hold_full <= 1'b1;
      end else if (boundary && hold_full) begin
        hold_full <= 1'b0;
      end
    end
  end

endmodule
